// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs feeding two round-robin broadcast slots.
// Optional same-cycle bypass of an empty FIFO is enabled by defining CDB_BYPASS_EN.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_W      = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              has_misbranch,
  input  logic              in_alu_valid,
  input  logic [ROB_W-1:0]  in_alu_robnum,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic              in_slb_valid,
  input  logic [ROB_W-1:0]  in_slb_robnum,
  input  logic [DATA_W-1:0] in_slb_data,
  input  logic              in_aux_valid,
  input  logic [ROB_W-1:0]  in_aux_robnum,
  input  logic [DATA_W-1:0] in_aux_data,
  output logic              out_alu_ready,
  output logic              out_slb_ready,
  output logic              out_aux_ready,
  output logic              has_rd_ready_1,
  output logic              has_rd_ready_2,
  output logic [ROB_W-1:0]  ready_robnum_1,
  output logic [ROB_W-1:0]  ready_robnum_2,
  output logic [DATA_W-1:0] ready_data_1,
  output logic [DATA_W-1:0] ready_data_2
);

  localparam int NSRC  = 3;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ROB_W-1:0]  memRob_q  [NSRC][FIFO_DEPTH];
  logic [DATA_W-1:0] memData_q [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  rdPtr_q   [NSRC];
  logic [PTR_W-1:0]  wrPtr_q   [NSRC];
  logic [CNT_W-1:0]  count_q   [NSRC];
  logic [1:0]        rrPtr_q;
  logic [1:0]        rrPtr_d;
  logic              slot1Valid_q, slot2Valid_q;
  logic [ROB_W-1:0]  slot1Rob_q, slot2Rob_q;
  logic [DATA_W-1:0] slot1Data_q, slot2Data_q;

  logic [NSRC-1:0]   inValid;
  logic [ROB_W-1:0]  inRob  [NSRC];
  logic [DATA_W-1:0] inData [NSRC];
  logic [NSRC-1:0]   srcReady, accept, fifoHas, cand, grant, push, pop;
  logic              g1Found, g2Found;
  logic [1:0]        g1Idx, g2Idx;
  logic [ROB_W-1:0]  slot1Rob_d, slot2Rob_d;
  logic [DATA_W-1:0] slot1Data_d, slot2Data_d;

  function automatic logic [1:0] rrAdd(input logic [1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NSRC) t = t - NSRC;
    return t[1:0];
  endfunction

  assign inValid   = {in_aux_valid, in_slb_valid, in_alu_valid};
  assign inRob[0]  = in_alu_robnum;
  assign inRob[1]  = in_slb_robnum;
  assign inRob[2]  = in_aux_robnum;
  assign inData[0] = in_alu_data;
  assign inData[1] = in_slb_data;
  assign inData[2] = in_aux_data;

  // Ready uses only the registered count, so a full FIFO refuses input even while draining.
  always_comb begin
    srcReady = '0;
    accept   = '0;
    fifoHas  = '0;
    cand     = '0;
    for (int s = 0; s < NSRC; s++) begin
      srcReady[s] = rdy && (count_q[s] < DEPTH_C);
      accept[s]   = inValid[s] && srcReady[s] && !has_misbranch;
      fifoHas[s]  = (count_q[s] != '0);
`ifdef CDB_BYPASS_EN
      cand[s]     = fifoHas[s] || accept[s];
`else
      cand[s]     = fifoHas[s];
`endif
    end
  end

  always_comb begin
    g1Found = 1'b0;
    g2Found = 1'b0;
    g1Idx   = 2'd0;
    g2Idx   = 2'd0;
    grant   = '0;
    for (int off = 0; off < NSRC; off++) begin
      if (cand[rrAdd(rrPtr_q, off)]) begin
        if (!g1Found) begin
          g1Found = 1'b1;
          g1Idx   = rrAdd(rrPtr_q, off);
        end else if (!g2Found) begin
          g2Found = 1'b1;
          g2Idx   = rrAdd(rrPtr_q, off);
        end
      end
    end
    if (g1Found) grant[g1Idx] = 1'b1;
    if (g2Found) grant[g2Idx] = 1'b1;
    if (g2Found)      rrPtr_d = rrAdd(g2Idx, 1);
    else if (g1Found) rrPtr_d = rrAdd(g1Idx, 1);
    else              rrPtr_d = rrPtr_q;
  end

  // A grant to an empty FIFO can only be a bypass: that result skips the FIFO entirely.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      pop[s]  = grant[s] && fifoHas[s];
      push[s] = accept[s] && !(grant[s] && !fifoHas[s]);
    end
    slot1Rob_d  = fifoHas[g1Idx] ? memRob_q[g1Idx][rdPtr_q[g1Idx]]  : inRob[g1Idx];
    slot1Data_d = fifoHas[g1Idx] ? memData_q[g1Idx][rdPtr_q[g1Idx]] : inData[g1Idx];
    slot2Rob_d  = fifoHas[g2Idx] ? memRob_q[g2Idx][rdPtr_q[g2Idx]]  : inRob[g2Idx];
    slot2Data_d = fifoHas[g2Idx] ? memData_q[g2Idx][rdPtr_q[g2Idx]] : inData[g2Idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NSRC; s++) begin
        rdPtr_q[s] <= '0;
        wrPtr_q[s] <= '0;
        count_q[s] <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          memRob_q[s][e]  <= '0;
          memData_q[s][e] <= '0;
        end
      end
    end else if (rdy) begin
      if (has_misbranch) begin
        for (int s = 0; s < NSRC; s++) begin
          rdPtr_q[s] <= '0;
          wrPtr_q[s] <= '0;
          count_q[s] <= '0;
        end
      end else begin
        for (int s = 0; s < NSRC; s++) begin
          if (push[s]) begin
            memRob_q[s][wrPtr_q[s]]  <= inRob[s];
            memData_q[s][wrPtr_q[s]] <= inData[s];
            wrPtr_q[s]               <= wrPtr_q[s] + PTR_W'(1);
          end
          if (pop[s]) rdPtr_q[s] <= rdPtr_q[s] + PTR_W'(1);
          count_q[s] <= count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
        end
      end
    end
  end

  // Invalid slots keep their last robnum/data; only the valid bits are cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr_q      <= 2'd0;
      slot1Valid_q <= 1'b0;
      slot2Valid_q <= 1'b0;
      slot1Rob_q   <= '0;
      slot2Rob_q   <= '0;
      slot1Data_q  <= '0;
      slot2Data_q  <= '0;
    end else if (rdy) begin
      if (has_misbranch) begin
        rrPtr_q      <= 2'd0;
        slot1Valid_q <= 1'b0;
        slot2Valid_q <= 1'b0;
      end else begin
        rrPtr_q      <= rrPtr_d;
        slot1Valid_q <= g1Found;
        slot2Valid_q <= g2Found;
        if (g1Found) begin
          slot1Rob_q  <= slot1Rob_d;
          slot1Data_q <= slot1Data_d;
        end
        if (g2Found) begin
          slot2Rob_q  <= slot2Rob_d;
          slot2Data_q <= slot2Data_d;
        end
      end
    end
  end

  assign out_alu_ready  = srcReady[0];
  assign out_slb_ready  = srcReady[1];
  assign out_aux_ready  = srcReady[2];
  assign has_rd_ready_1 = slot1Valid_q;
  assign has_rd_ready_2 = slot2Valid_q;
  assign ready_robnum_1 = slot1Rob_q;
  assign ready_robnum_2 = slot2Rob_q;
  assign ready_data_1   = slot1Data_q;
  assign ready_data_2   = slot2Data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter in its default (no bypass) build.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        has_misbranch;
  logic        in_alu_valid, in_slb_valid, in_aux_valid;
  logic [3:0]  in_alu_robnum, in_slb_robnum, in_aux_robnum;
  logic [31:0] in_alu_data, in_slb_data, in_aux_data;
  logic        out_alu_ready, out_slb_ready, out_aux_ready;
  logic        has_rd_ready_1, has_rd_ready_2;
  logic [3:0]  ready_robnum_1, ready_robnum_2;
  logic [31:0] ready_data_1, ready_data_2;

  int compared;
  int mismatched;
  int nextSeq [3];

  cdb_arbiter #(.FIFO_DEPTH(4), .ROB_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
    .in_alu_valid(in_alu_valid), .in_alu_robnum(in_alu_robnum), .in_alu_data(in_alu_data),
    .in_slb_valid(in_slb_valid), .in_slb_robnum(in_slb_robnum), .in_slb_data(in_slb_data),
    .in_aux_valid(in_aux_valid), .in_aux_robnum(in_aux_robnum), .in_aux_data(in_aux_data),
    .out_alu_ready(out_alu_ready), .out_slb_ready(out_slb_ready), .out_aux_ready(out_aux_ready),
    .has_rd_ready_1(has_rd_ready_1), .has_rd_ready_2(has_rd_ready_2),
    .ready_robnum_1(ready_robnum_1), .ready_robnum_2(ready_robnum_2),
    .ready_data_1(ready_data_1), .ready_data_2(ready_data_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic aV, input logic [3:0] aR, input logic [31:0] aD,
                               input logic sV, input logic [3:0] sR, input logic [31:0] sD,
                               input logic xV, input logic [3:0] xR, input logic [31:0] xD);
    in_alu_valid = aV; in_alu_robnum = aR; in_alu_data = aD;
    in_slb_valid = sV; in_slb_robnum = sR; in_slb_data = sD;
    in_aux_valid = xV; in_aux_robnum = xR; in_aux_data = xD;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic resetPulse();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  // Per-source ordering: data carries {source, sequence} so each source must drain 0,1,2...
  task automatic collectBroadcast(input logic v, input logic [31:0] d);
    logic [3:0] src;
    if (v) begin
      src = d[11:8];
      if (src < 4'd3) begin
        checkOutput("bp_order", 64'(d), 64'((int'(src) << 8) + nextSeq[src]));
        nextSeq[src]++;
      end else begin
        checkOutput("bp_src", 64'(src), 64'(0));
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    rdy = 1'b0;
    has_misbranch = 1'b0;
    clearInputs();

    // Reset state
    #2;
    checkOutput("rst_v1", 64'(has_rd_ready_1), 64'(0));
    checkOutput("rst_v2", 64'(has_rd_ready_2), 64'(0));
    checkOutput("rst_rob1", 64'(ready_robnum_1), 64'(0));
    checkOutput("rst_data2", 64'(ready_data_2), 64'(0));
    checkOutput("rst_ready_rdy0", 64'(out_alu_ready), 64'(0));
    rdy = 1'b1;
    #1;
    checkOutput("rst_ready_rdy1", 64'({out_alu_ready, out_slb_ready, out_aux_ready}), 64'(7));

    // Single result, latency 2
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 4'd5, 32'h0000_00AB, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("single_k1_v1", 64'(has_rd_ready_1), 64'(0));
    clearInputs();
    @(negedge clk);
    checkOutput("single_k2_v1", 64'(has_rd_ready_1), 64'(1));
    checkOutput("single_k2_rob1", 64'(ready_robnum_1), 64'(5));
    checkOutput("single_k2_data1", 64'(ready_data_1), 64'h0000_00AB);
    checkOutput("single_k2_v2", 64'(has_rd_ready_2), 64'(0));
    checkOutput("single_k2_data2", 64'(ready_data_2), 64'(0));
    @(negedge clk);
    checkOutput("single_k3_v1", 64'(has_rd_ready_1), 64'(0));
    checkOutput("single_k3_rob1_hold", 64'(ready_robnum_1), 64'(5));
    checkOutput("single_rr", 64'(dut.rrPtr_q), 64'(1));

    // Triple collision
    resetPulse();
    applyStimulus(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b1, 4'd3, 32'h33);
    @(negedge clk);
    checkOutput("tri_c1_v1", 64'(has_rd_ready_1), 64'(0));
    clearInputs();
    @(negedge clk);
    checkOutput("tri_c2_v1", 64'(has_rd_ready_1), 64'(1));
    checkOutput("tri_c2_rob1", 64'(ready_robnum_1), 64'(1));
    checkOutput("tri_c2_data1", 64'(ready_data_1), 64'h11);
    checkOutput("tri_c2_v2", 64'(has_rd_ready_2), 64'(1));
    checkOutput("tri_c2_rob2", 64'(ready_robnum_2), 64'(2));
    checkOutput("tri_c2_data2", 64'(ready_data_2), 64'h22);
    @(negedge clk);
    checkOutput("tri_c3_v1", 64'(has_rd_ready_1), 64'(1));
    checkOutput("tri_c3_rob1", 64'(ready_robnum_1), 64'(3));
    checkOutput("tri_c3_data1", 64'(ready_data_1), 64'h33);
    checkOutput("tri_c3_v2", 64'(has_rd_ready_2), 64'(0));
    checkOutput("tri_c3_rob2_hold", 64'(ready_robnum_2), 64'(2));
    checkOutput("tri_rr", 64'(dut.rrPtr_q), 64'(0));
    @(negedge clk);
    checkOutput("tri_c4_v1", 64'(has_rd_ready_1), 64'(0));

    // Backpressure: all three sources stream for 9 cycles, 3 in / 2 out per cycle
    resetPulse();
    nextSeq[0] = 0;
    nextSeq[1] = 0;
    nextSeq[2] = 0;
    for (int i = 1; i <= 40; i++) begin
      collectBroadcast(has_rd_ready_1, ready_data_1);
      collectBroadcast(has_rd_ready_2, ready_data_2);
      if (i <= 10) checkOutput($sformatf("bp_slb_ready_%0d", i), 64'(out_slb_ready), 64'(i <= 9));
      if (i == 9) checkOutput("bp_aux_full", 64'(out_aux_ready), 64'(0));
      if (i == 10) checkOutput("bp_alu_ready", 64'(out_alu_ready), 64'(1));
      if (i <= 9)
        applyStimulus(1'b1, 4'(i - 1), 32'(32'h000 + i - 1),
                      1'b1, 4'(i - 1), 32'(32'h100 + i - 1),
                      1'b1, 4'(i - 1), 32'(32'h200 + i - 1));
      else
        clearInputs();
      @(negedge clk);
    end
    checkOutput("bp_alu_total", 64'(nextSeq[0]), 64'(9));
    checkOutput("bp_slb_total", 64'(nextSeq[1]), 64'(9));
    checkOutput("bp_aux_total", 64'(nextSeq[2]), 64'(8));

    // Flush with queued entries and pending grants
    resetPulse();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 4'(i), 32'(i), 1'b1, 4'(i), 32'(i), 1'b1, 4'(i), 32'(i));
      @(negedge clk);
    end
    checkOutput("flush_pre_v1", 64'(has_rd_ready_1), 64'(1));
    checkOutput("flush_pre_v2", 64'(has_rd_ready_2), 64'(1));
    has_misbranch = 1'b1;
    @(negedge clk);
    checkOutput("flush_v1", 64'(has_rd_ready_1), 64'(0));
    checkOutput("flush_v2", 64'(has_rd_ready_2), 64'(0));
    checkOutput("flush_ready", 64'({out_alu_ready, out_slb_ready, out_aux_ready}), 64'(7));
    checkOutput("flush_rr", 64'(dut.rrPtr_q), 64'(0));
    has_misbranch = 1'b0;
    clearInputs();
    @(negedge clk);
    checkOutput("flush_empty_v1", 64'(has_rd_ready_1), 64'(0));
    checkOutput("flush_empty_v2", 64'(has_rd_ready_2), 64'(0));
    applyStimulus(1'b1, 4'd9, 32'hC9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("flush_post_k1_v1", 64'(has_rd_ready_1), 64'(0));
    clearInputs();
    @(negedge clk);
    checkOutput("flush_post_k2_v1", 64'(has_rd_ready_1), 64'(1));
    checkOutput("flush_post_k2_rob1", 64'(ready_robnum_1), 64'(9));
    checkOutput("flush_post_k2_data1", 64'(ready_data_1), 64'hC9);
    checkOutput("flush_post_k2_v2", 64'(has_rd_ready_2), 64'(0));

    // Freeze for 3 cycles while slots are valid and the aux FIFO holds one entry
    resetPulse();
    applyStimulus(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hA2, 1'b1, 4'd3, 32'hA3);
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    checkOutput("frz_pre_rob1", 64'(ready_robnum_1), 64'(1));
    checkOutput("frz_pre_rob2", 64'(ready_robnum_2), 64'(2));
    rdy = 1'b0;
    applyStimulus(1'b1, 4'd7, 32'hA7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    #1;
    checkOutput("frz_ready", 64'({out_alu_ready, out_slb_ready, out_aux_ready}), 64'(0));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("frz_hold_v1_%0d", i), 64'(has_rd_ready_1), 64'(1));
      checkOutput($sformatf("frz_hold_data1_%0d", i), 64'(ready_data_1), 64'hA1);
      checkOutput($sformatf("frz_hold_v2_%0d", i), 64'(has_rd_ready_2), 64'(1));
      checkOutput($sformatf("frz_hold_rob2_%0d", i), 64'(ready_robnum_2), 64'(2));
    end
    rdy = 1'b1;
    clearInputs();
    @(negedge clk);
    checkOutput("frz_after_v1", 64'(has_rd_ready_1), 64'(1));
    checkOutput("frz_after_rob1", 64'(ready_robnum_1), 64'(3));
    checkOutput("frz_after_data1", 64'(ready_data_1), 64'hA3);
    checkOutput("frz_after_v2", 64'(has_rd_ready_2), 64'(0));

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_v1", 64'(has_rd_ready_1), 64'(0));
    checkOutput("arst_rob1", 64'(ready_robnum_1), 64'(0));
    checkOutput("arst_data1", 64'(ready_data_1), 64'(0));
    checkOutput("arst_rob2", 64'(ready_robnum_2), 64'(0));
    checkOutput("arst_rr", 64'(dut.rrPtr_q), 64'(0));
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus scheduler between the result producers (ALU, load/store buffer, auxiliary unit) and the two broadcast slots consumed by the ROB, RS and SLB. It queues each producer's results in a private FIFO, then grants up to two broadcasts per cycle with round-robin fairness. It replaces direct producer-to-ROB wiring so no result is dropped when producers finish together. The whole queue is flushed on misbranch.

## Interface
- `FIFO_DEPTH`, default 4: entries per source FIFO; power of 2, at least 2.
- `ROB_W`, default 4: ROB index width.
- `DATA_W`, default 32: result data width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global enable; low freezes all state.
- `has_misbranch`  in  1  flush request.
- `in_alu_valid` / `in_slb_valid` / `in_aux_valid`  in  1  each: result present from that source.
- `in_alu_robnum` / `in_slb_robnum` / `in_aux_robnum`  in  ROB_W  each: destination ROB entry.
- `in_alu_data` / `in_slb_data` / `in_aux_data`  in  DATA_W  each: result value.
- `out_alu_ready` / `out_slb_ready` / `out_aux_ready`  out  1  each: source may present a result this cycle.
- `has_rd_ready_1` / `has_rd_ready_2`  out  1  each: broadcast slot valid.
- `ready_robnum_1` / `ready_robnum_2`  out  ROB_W  each: broadcast ROB index.
- `ready_data_1` / `ready_data_2`  out  DATA_W  each: broadcast value.

## Operation
- Source index order: alu=0, slb=1, aux=2.
- **Ready and accept**
  - `out_X_ready` = `rdy` AND (registered count of FIFO X < FIFO_DEPTH).
  - Ready does not look ahead to a same-cycle drain, so a full FIFO refuses input even in a cycle it drains.
  - A transfer happens at an edge where valid, ready, `rdy` and not `has_misbranch` are all high.
- **Arbitration** (each cycle, `rdy` high, no flush)
  - Candidates are the sources whose FIFO is non-empty.
  - Slot 1 takes the first candidate at or after `rr_ptr`, searching modulo 3.
  - Slot 2 takes the next distinct candidate after it.
  - A source gets at most one grant per cycle.
  - With a single grant, it always goes to slot 1 and slot 2 is invalid.
  - `rr_ptr` (2 bits, values 0..2) moves to (last granted index + 1) mod 3; it is unchanged when nothing is granted.
- **Output registers**
  - A granted head is popped and loaded into the slot register.
  - An ungranted slot loads valid=0.
  - Robnum/data of an invalid slot hold their previous value.
- **FIFO**
  - Circular buffer per source, with ptr widths log2(FIFO_DEPTH) and count width log2(FIFO_DEPTH)+1.
  - Pointers wrap from FIFO_DEPTH-1 to 0.
  - A push and a pop in the same cycle leave count unchanged.
- **Flush**: `has_misbranch` high with `rdy` high causes, at that edge:
  - every FIFO emptied (pointers and counts to 0);
  - both slot valids cleared;
  - `rr_ptr` set to 0;
  - that cycle's inputs discarded.
- **Freeze**: `rdy` low means no state changes, and outputs hold their values (a held valid remains asserted).
- **Reset**: every register is 0, so every `has_rd_ready_*`, `ready_robnum_*` and `ready_data_*` is 0 and `rr_ptr` is 0. `out_X_ready` follows `rdy`.

## Timing
- Cycle k spans edge k to edge k+1.
- Result accepted in cycle k (FIFO empty, no contention):
  - without bypass: pushed at edge k+1, granted in cycle k+1, broadcast visible in cycle k+2 (latency 2);
  - with bypass: see Configuration (latency 1).
- Sustained throughput is 2 results per cycle.
- Worst-case wait for a non-empty FIFO head is 1 cycle (round-robin over 3 sources with 2 slots).
- Reset mid-operation is asynchronous: all state clears immediately, independent of `clk`.
- A misbranch in the same cycle as a pending grant: the flush wins, and no broadcast appears in the next cycle.

## Configuration
- Macro: `CDB_BYPASS_EN`.
- **Defined**: an input transfer from a source whose FIFO is empty (count 0 at the start of the cycle) is arbitration-eligible in the same cycle.
  - If it is granted, its data goes straight into the slot register (latency 1) and is not pushed.
  - If it is not granted, it is pushed normally.
  - A source with a non-empty FIFO is never bypassed, which preserves per-source order.
- **Undefined**: every result passes through the FIFO (latency 2), and arbitration considers only FIFO heads.

## Test plan
- **Single result**: reset, `rdy`=1, ALU presents robnum 5 / data 0x0000_00AB for one cycle.
  - Without bypass: `has_rd_ready_1`=1 with 5 / 0xAB in cycle k+2 only, and slot 2 stays 0.
  - With bypass: the same appears in cycle k+1.
- **Triple collision**: all three sources present in the same cycle (robnums 1, 2, 3).
  - First broadcast cycle: slot 1 = 1 and slot 2 = 2.
  - Next cycle: slot 1 = 3 and slot 2 invalid.
  - Final `rr_ptr` = 0.
- **Backpressure**: SLB presents continuously while the ALU and aux sources keep the SLB from being granted.
  - `out_slb_ready` drops after FIFO_DEPTH accepts.
  - No entry is lost, and the order is preserved on drain.
- **Flush**: 3 entries queued in the ALU FIFO, then `has_misbranch` pulses high for one cycle.
  - Next cycle: both valids are 0 and every ready is 1.
  - A subsequent input is broadcast normally with the first-broadcast latency.
- **Freeze and reset**:
  - `rdy`=0 for 3 cycles while slot 1 is valid: outputs hold, and the FIFO is unchanged.
  - Asserting `rst`=0 between clock edges clears all outputs immediately.
